// File: rtl/mano_control_unit_pkg.sv
// Shared encodings for the MANO timing-and-control stage: bus sources, ALU ops,
// opcode decode indices and register-reference / I/O micro-op bit positions.
package mano_control_unit_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [2:0] {
    ALU_AND       = 3'd0,
    ALU_ADD       = 3'd1,
    ALU_PASS_DR   = 3'd2,
    ALU_PASS_INPR = 3'd3,
    ALU_CMA       = 3'd4,
    ALU_SHR       = 3'd5,
    ALU_SHL       = 3'd6
  } alu_op_e;

  // Opcode decode indices D0..D7
  localparam int unsigned D_AND = 0;
  localparam int unsigned D_ADD = 1;
  localparam int unsigned D_LDA = 2;
  localparam int unsigned D_STA = 3;
  localparam int unsigned D_BUN = 4;
  localparam int unsigned D_BSA = 5;
  localparam int unsigned D_ISZ = 6;
  localparam int unsigned D_REG = 7;

  // Register-reference micro-op bits in IR[11:0]
  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  // I/O micro-op bits in IR[11:0]
  localparam int unsigned IO_INP = 11;
  localparam int unsigned IO_OUT = 10;
  localparam int unsigned IO_SKI = 9;
  localparam int unsigned IO_SKO = 8;
  localparam int unsigned IO_ION = 7;
  localparam int unsigned IO_IOF = 6;

  // Highest timing state used by legal instruction flow
  localparam int unsigned T_LAST = 6;

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with increment/clear (clear wins) and a one-hot Tn decoder.
module mano_seq_counter #(
  parameter int unsigned SC_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [2**SC_WIDTH-1:0]   t_c
);

  logic [SC_WIDTH-1:0] sc;

  always_ff @(posedge clk) begin
    if (rst)      sc <= '0;
    else if (clr) sc <= '0;
    else if (inc) sc <= sc + SC_WIDTH'(1);
  end

  // One-hot timing state decode
  always_comb begin
    t_c     = '0;
    t_c[sc] = 1'b1;
  end

endmodule

// File: rtl/mano_control_unit.sv
// MANO CPU timing and control: SC plus I/S/IEN/R flip-flops, decoding IR, Tn and
// status flags into per-register strobes, bus select, ALU op and memory write.
module mano_control_unit
  import mano_control_unit_pkg::*;
#(
  parameter int unsigned SC_WIDTH = 4,
  parameter int unsigned WORD     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [WORD-1:0] ir,
  input  logic            dr_zero,
  input  logic            ac_zero,
  input  logic            ac_sign,
  input  logic            e_in,
  input  logic            fgi,
  input  logic            fgo,
  output logic            ar_ld,
  output logic            ar_inc,
  output logic            ar_clr,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            pc_clr,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            ac_ld,
  output logic            ac_inc,
  output logic            ac_clr,
  output logic            ir_ld,
  output logic            tr_ld,
  output logic            outr_ld,
  output logic            mem_write,
  output logic [2:0]      bus_sel,
  output logic [2:0]      alu_op,
  output logic            e_clr,
  output logic            e_cmp,
  output logic            fgi_clr,
  output logic            fgo_clr,
  output logic            halted
);

  localparam int unsigned NUM_T = 2**SC_WIDTH;

  logic [NUM_T-1:0] t;
  logic [7:0]       d;
  logic [11:0]      b;
  logic s, ien, r, i_ff;
  logic s_next, ien_next, r_next, i_next;
  logic sc_inc, sc_clr, fin, skip, illegal, active;
  logic ac_clr_req, ac_inc_req, ac_ld_req;

  assign d       = 8'(1) << ir[WORD-2:WORD-4];
  assign b       = ir[11:0];
  assign illegal = |t[NUM_T-1:T_LAST+1];
  assign active  = s & ~rst;
  assign halted  = ~s;
  assign sc_inc  = s;
  assign sc_clr  = fin | (s & illegal);

  mano_seq_counter #(.SC_WIDTH(SC_WIDTH)) u_sc (
    .clk (clk),
    .rst (rst),
    .inc (sc_inc),
    .clr (sc_clr),
    .t_c (t)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s    <= 1'b1;
      ien  <= 1'b0;
      r    <= 1'b0;
      i_ff <= 1'b0;
    end else begin
      s    <= s_next;
      ien  <= ien_next;
      r    <= r_next;
      i_ff <= i_next;
    end
  end

  // Control decode: fetch/interrupt cycle, then execute phase, then AC arbitration
  always_comb begin
    ar_ld = 1'b0; ar_inc = 1'b0; ar_clr = 1'b0;
    pc_ld = 1'b0; pc_inc = 1'b0; pc_clr = 1'b0;
    dr_ld = 1'b0; dr_inc = 1'b0;
    ir_ld = 1'b0; tr_ld = 1'b0; outr_ld = 1'b0; mem_write = 1'b0;
    e_clr = 1'b0; e_cmp = 1'b0; fgi_clr = 1'b0; fgo_clr = 1'b0;
    bus_sel = BUS_NONE;
    alu_op  = ALU_AND;
    ac_clr_req = 1'b0; ac_inc_req = 1'b0; ac_ld_req = 1'b0;
    skip = 1'b0; fin = 1'b0;
    s_next = s; ien_next = ien; r_next = r; i_next = i_ff;

    if (active) begin
      if (!r) begin
        if (t[0]) begin bus_sel = BUS_PC;  ar_ld = 1'b1; end
        if (t[1]) begin bus_sel = BUS_MEM; ir_ld = 1'b1; pc_inc = 1'b1; end
        if (t[2]) begin bus_sel = BUS_IR;  ar_ld = 1'b1; i_next = ir[WORD-1]; end
      end else begin
        if (t[0]) begin bus_sel = BUS_PC; ar_clr = 1'b1; tr_ld = 1'b1; end
        if (t[1]) begin bus_sel = BUS_TR; mem_write = 1'b1; pc_clr = 1'b1; end
        if (t[2]) begin pc_inc = 1'b1; ien_next = 1'b0; r_next = 1'b0; fin = 1'b1; end
      end

      if (!d[D_REG]) begin
        if (t[3] && i_ff) begin bus_sel = BUS_MEM; ar_ld = 1'b1; end
        if (d[D_AND] || d[D_ADD] || d[D_LDA]) begin
          if (t[4]) begin bus_sel = BUS_MEM; dr_ld = 1'b1; end
          if (t[5]) begin
            ac_ld_req = 1'b1;
            fin       = 1'b1;
            if (d[D_AND])      alu_op = ALU_AND;
            else if (d[D_ADD]) alu_op = ALU_ADD;
            else               alu_op = ALU_PASS_DR;
          end
        end
        if (d[D_STA] && t[4]) begin bus_sel = BUS_AC; mem_write = 1'b1; fin = 1'b1; end
        if (d[D_BUN] && t[4]) begin bus_sel = BUS_AR; pc_ld = 1'b1; fin = 1'b1; end
        if (d[D_BSA]) begin
          if (t[4]) begin bus_sel = BUS_PC; mem_write = 1'b1; ar_inc = 1'b1; end
          if (t[5]) begin bus_sel = BUS_AR; pc_ld = 1'b1; fin = 1'b1; end
        end
        if (d[D_ISZ]) begin
          if (t[4]) begin bus_sel = BUS_MEM; dr_ld = 1'b1; end
          if (t[5]) dr_inc = 1'b1;
          if (t[6]) begin bus_sel = BUS_DR; mem_write = 1'b1; skip = dr_zero; fin = 1'b1; end
        end
      end else if (t[3]) begin
        fin = 1'b1;
        if (!i_ff) begin
          // Later ALU assignments win when several AC-loading micro-ops are selected
          if (b[RR_CLA]) ac_clr_req = 1'b1;
          if (b[RR_CLE]) e_clr = 1'b1;
          if (b[RR_CME]) e_cmp = 1'b1;
          if (b[RR_CIL]) begin ac_ld_req = 1'b1; alu_op = ALU_SHL; end
          if (b[RR_CIR]) begin ac_ld_req = 1'b1; alu_op = ALU_SHR; end
          if (b[RR_CMA]) begin ac_ld_req = 1'b1; alu_op = ALU_CMA; end
          if (b[RR_INC]) ac_inc_req = 1'b1;
          if (b[RR_SPA] && !ac_sign) skip = 1'b1;
          if (b[RR_SNA] &&  ac_sign) skip = 1'b1;
          if (b[RR_SZA] &&  ac_zero) skip = 1'b1;
          if (b[RR_SZE] && !e_in)    skip = 1'b1;
          if (b[RR_HLT]) s_next = 1'b0;
        end else begin
          if (b[IO_INP]) begin ac_ld_req = 1'b1; alu_op = ALU_PASS_INPR; fgi_clr = 1'b1; end
          if (b[IO_OUT]) begin bus_sel = BUS_AC; outr_ld = 1'b1; fgo_clr = 1'b1; end
          if (b[IO_SKI] && fgi) skip = 1'b1;
          if (b[IO_SKO] && fgo) skip = 1'b1;
          if (b[IO_ION]) ien_next = 1'b1;
          if (b[IO_IOF]) ien_next = 1'b0;
        end
      end

      if (ien && (fgi || fgo) && !(t[0] || t[1] || t[2])) r_next = 1'b1;
      if (skip) pc_inc = 1'b1;
    end

    // One AC strobe per cycle: clear over increment over load
    ac_clr = ac_clr_req;
    ac_inc = ac_inc_req & ~ac_clr_req;
    ac_ld  = ac_ld_req & ~ac_clr_req & ~ac_inc_req;
  end

endmodule

// File: tb/tb_mano_control_unit.sv
// Directed bench for mano_control_unit: expected strobe sets are queued per cycle
// and compared against the DUT outputs mid-cycle.
module tb_mano_control_unit;

  logic clk, rst;
  logic [15:0] ir;
  logic dr_zero, ac_zero, ac_sign, e_in, fgi, fgo;
  logic ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc;
  logic ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_write;
  logic [2:0] bus_sel, alu_op;
  logic e_clr, e_cmp, fgi_clr, fgo_clr, halted;

  mano_control_unit dut (
    .clk(clk), .rst(rst), .ir(ir), .dr_zero(dr_zero), .ac_zero(ac_zero),
    .ac_sign(ac_sign), .e_in(e_in), .fgi(fgi), .fgo(fgo),
    .ar_ld(ar_ld), .ar_inc(ar_inc), .ar_clr(ar_clr),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr),
    .dr_ld(dr_ld), .dr_inc(dr_inc),
    .ac_ld(ac_ld), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .ir_ld(ir_ld), .tr_ld(tr_ld), .outr_ld(outr_ld), .mem_write(mem_write),
    .bus_sel(bus_sel), .alu_op(alu_op),
    .e_clr(e_clr), .e_cmp(e_cmp), .fgi_clr(fgi_clr), .fgo_clr(fgo_clr),
    .halted(halted)
  );

  localparam logic [19:0] NONE    = 20'h00000;
  localparam logic [19:0] AR_LD   = 20'h80000;
  localparam logic [19:0] AR_INC  = 20'h40000;
  localparam logic [19:0] AR_CLR  = 20'h20000;
  localparam logic [19:0] PC_LD   = 20'h10000;
  localparam logic [19:0] PC_INC  = 20'h08000;
  localparam logic [19:0] PC_CLR  = 20'h04000;
  localparam logic [19:0] DR_LD   = 20'h02000;
  localparam logic [19:0] DR_INC  = 20'h01000;
  localparam logic [19:0] AC_LD   = 20'h00800;
  localparam logic [19:0] AC_INC  = 20'h00400;
  localparam logic [19:0] AC_CLR  = 20'h00200;
  localparam logic [19:0] IR_LD   = 20'h00100;
  localparam logic [19:0] TR_LD   = 20'h00080;
  localparam logic [19:0] OUTR_LD = 20'h00040;
  localparam logic [19:0] MEM_WR  = 20'h00020;
  localparam logic [19:0] E_CLR   = 20'h00010;
  localparam logic [19:0] E_CMP   = 20'h00008;
  localparam logic [19:0] FGI_CLR = 20'h00004;
  localparam logic [19:0] FGO_CLR = 20'h00002;
  localparam logic [19:0] HALT    = 20'h00001;

  localparam logic [2:0] B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
  localparam logic [2:0] B_AC = 3'd4, B_IR = 3'd5, B_TR = 3'd6, B_MEM = 3'd7;
  localparam logic [2:0] A_AND = 3'd0, A_ADD = 3'd1, A_PDR = 3'd2, A_INPR = 3'd3;
  localparam logic [2:0] A_CMA = 3'd4, A_SHR = 3'd5;

  typedef struct {
    string       tag;
    logic [25:0] exp;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [25:0] obs;

  assign obs = {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld, dr_inc,
                ac_ld, ac_inc, ac_clr, ir_ld, tr_ld, outr_ld, mem_write,
                e_clr, e_cmp, fgi_clr, fgo_clr, halted, bus_sel, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Queue this cycle's expectation, compare on the falling edge, advance one clock
  task automatic step(input string tag, input logic [19:0] f, input logic [2:0] bs,
                      input logic [2:0] al);
    exp_t e;
    e.tag = tag;
    e.exp = {f, bs, al};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk(e.tag, 32'(obs), 32'(e.exp));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [15:0] w);
    ir = w;
    step({tag, ".T0"}, AR_LD, B_PC, A_AND);
    step({tag, ".T1"}, IR_LD | PC_INC, B_MEM, A_AND);
    step({tag, ".T2"}, AR_LD, B_IR, A_AND);
  endtask

  initial begin
    rst = 1'b1; ir = 16'h0000; dr_zero = 1'b0; ac_zero = 1'b0; ac_sign = 1'b0;
    e_in = 1'b0; fgi = 1'b0; fgo = 1'b0;
    @(posedge clk);
    #1;
    step("rst.hold", NONE, B_NONE, A_AND);
    rst = 1'b0;
    chk("rst.sc", 32'(dut.u_sc.sc), 32'd0);
    chk("rst.ien", 32'(dut.ien), 32'd0);

    fetch("cla", 16'h7800);
    step("cla.T3", AC_CLR, B_NONE, A_AND);
    chk("cla.sc_cleared", 32'(dut.u_sc.sc), 32'd0);

    fetch("add", 16'h1005);
    step("add.T3", NONE, B_NONE, A_AND);
    step("add.T4", DR_LD, B_MEM, A_AND);
    step("add.T5", AC_LD, B_NONE, A_ADD);
    chk("add.sc_cleared", 32'(dut.u_sc.sc), 32'd0);

    fetch("addi", 16'h9005);
    step("addi.T3", AR_LD, B_MEM, A_AND);
    step("addi.T4", DR_LD, B_MEM, A_AND);
    step("addi.T5", AC_LD, B_NONE, A_ADD);

    fetch("lda", 16'h2005);
    step("lda.T3", NONE, B_NONE, A_AND);
    step("lda.T4", DR_LD, B_MEM, A_AND);
    step("lda.T5", AC_LD, B_NONE, A_PDR);

    fetch("sta", 16'h3005);
    step("sta.T3", NONE, B_NONE, A_AND);
    step("sta.T4", MEM_WR, B_AC, A_AND);

    fetch("bun", 16'h4005);
    step("bun.T3", NONE, B_NONE, A_AND);
    step("bun.T4", PC_LD, B_AR, A_AND);

    fetch("isz", 16'h6010);
    step("isz.T3", NONE, B_NONE, A_AND);
    step("isz.T4", DR_LD, B_MEM, A_AND);
    step("isz.T5", DR_INC, B_NONE, A_AND);
    dr_zero = 1'b1;
    step("isz.T6skip", MEM_WR | PC_INC, B_DR, A_AND);
    dr_zero = 1'b0;
    fetch("isz2", 16'h6010);
    step("isz2.T3", NONE, B_NONE, A_AND);
    step("isz2.T4", DR_LD, B_MEM, A_AND);
    step("isz2.T5", DR_INC, B_NONE, A_AND);
    step("isz2.T6", MEM_WR, B_DR, A_AND);

    fetch("bsa", 16'h5020);
    step("bsa.T3", NONE, B_NONE, A_AND);
    step("bsa.T4", MEM_WR | AR_INC, B_PC, A_AND);
    step("bsa.T5", PC_LD, B_AR, A_AND);

    // CLE + CIR + SPA (taken) + SZE (not taken)
    ac_sign = 1'b0; e_in = 1'b1;
    fetch("rr_multi", 16'h7492);
    step("rr_multi.T3", E_CLR | PC_INC | AC_LD, B_NONE, A_SHR);
    fetch("rr_cme_inc", 16'h7120);
    step("rr_cme_inc.T3", E_CMP | AC_INC, B_NONE, A_AND);
    fetch("rr_cma", 16'h7200);
    step("rr_cma.T3", AC_LD, B_NONE, A_CMA);
    ac_zero = 1'b0;
    fetch("sza_no", 16'h7004);
    step("sza_no.T3", NONE, B_NONE, A_AND);
    ac_sign = 1'b1;
    fetch("sna", 16'h7008);
    step("sna.T3", PC_INC, B_NONE, A_AND);
    ac_sign = 1'b0;

    fetch("inp", 16'hF800);
    step("inp.T3", AC_LD | FGI_CLR, B_NONE, A_INPR);
    fetch("out", 16'hF400);
    step("out.T3", OUTR_LD | FGO_CLR, B_AC, A_AND);
    fgi = 1'b1;
    fetch("ski", 16'hF200);
    step("ski.T3", PC_INC, B_NONE, A_AND);
    fgi = 1'b0;
    fetch("sko", 16'hF100);
    step("sko.T3", NONE, B_NONE, A_AND);

    // Interrupt entry after ION
    fetch("ion", 16'hF080);
    step("ion.T3", NONE, B_NONE, A_AND);
    chk("ion.ien", 32'(dut.ien), 32'd1);
    chk("ion.r", 32'(dut.r), 32'd0);
    fgi = 1'b1;
    fetch("irq", 16'h7800);
    chk("irq.r_not_in_fetch", 32'(dut.r), 32'd0);
    step("irq.T3", AC_CLR, B_NONE, A_AND);
    chk("irq.r_set", 32'(dut.r), 32'd1);
    step("irq.RT0", AR_CLR | TR_LD, B_PC, A_AND);
    step("irq.RT1", MEM_WR | PC_CLR, B_TR, A_AND);
    step("irq.RT2", PC_INC, B_NONE, A_AND);
    chk("irq.r_clr", 32'(dut.r), 32'd0);
    chk("irq.ien_clr", 32'(dut.ien), 32'd0);
    chk("irq.sc", 32'(dut.u_sc.sc), 32'd0);
    fgi = 1'b0;

    // Halt with IEN set, then reset
    fetch("ion2", 16'hF080);
    step("ion2.T3", NONE, B_NONE, A_AND);
    fetch("hlt", 16'h7001);
    step("hlt.T3", NONE, B_NONE, A_AND);
    chk("hlt.ien", 32'(dut.ien), 32'd1);
    fgo = 1'b1;
    ir  = 16'h7800;
    for (int k = 0; k < 20; k++) step("hlt.idle", HALT, B_NONE, A_AND);
    chk("hlt.sc_frozen", 32'(dut.u_sc.sc), 32'd0);
    chk("hlt.r", 32'(dut.r), 32'd0);
    fgo = 1'b0;
    rst = 1'b1;
    step("hlt.rst", HALT, B_NONE, A_AND);
    rst = 1'b0;
    chk("post.ien", 32'(dut.ien), 32'd0);
    chk("post.sc", 32'(dut.u_sc.sc), 32'd0);
    fetch("post", 16'h7800);
    step("post.T3", AC_CLR, B_NONE, A_AND);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
